ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 12: RAM address width in bits (RAM is 2^AW bytes).
REQ-002 SHALL have parameter LOAD_INDEX, default 8'd1: the ioctl_index value that selects a RAM image download.
REQ-003 SHALL have port clk, input, 1: system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ioctl_download, input, 1: download in progress.
REQ-006 SHALL have port ioctl_index, input, 8: download slot.
REQ-007 SHALL have port ioctl_wr, input, 1: one-clock byte strobe.
REQ-008 SHALL have port ioctl_addr, input, 25: byte address.
REQ-009 SHALL have port ioctl_dout, input, 8: byte data.
REQ-010 SHALL have ports cpu_req (input, 1), cpu_we (input, 1), cpu_addr (input, AW), cpu_wdata (input, 8): CPU access request.
REQ-011 SHALL have ports cpu_ack (output, 1) and cpu_rdata (output, 8): CPU completion pulse and read data.
REQ-012 SHALL have ports dma_req (input, 1) and dma_addr (input, AW): video DMA read request.
REQ-013 SHALL have ports dma_ack (output, 1) and dma_rdata (output, 8): DMA completion pulse and read data.
REQ-014 SHALL have ports ram_addr (output, AW), ram_we (output, 1), ram_wdata (output, 8), all registered, and ram_rdata (input, 8): synchronous RAM, read data valid one clock after the address.
REQ-015 SHALL have ports cpu_hold (output, 1): CPU hold; load_done (output, 1): one-clock pulse; overflow (output, 1): sticky flag.

Function
REQ-016 SHALL implement FSM states IDLE, ACC, DONE, LOAD, LWR and RELEASE.
REQ-017 In IDLE, each cycle SHALL select by priority: ioctl_download high with ioctl_index==LOAD_INDEX -> LOAD; else dma_req -> ACC(DMA); else cpu_req -> ACC(CPU). Entry is level-sensitive, not edge-sensitive.
REQ-018 ACC SHALL drive the winner's address on ram_addr; for CPU writes it SHALL also drive ram_we=1 and ram_wdata=cpu_wdata for exactly one cycle.
REQ-019 From ACC the FSM SHALL go to DONE; DONE SHALL pulse the winner's ack for one cycle with rdata=ram_rdata, then return to IDLE.
REQ-020 Latency SHALL be fixed: request sampled at edge k -> ack high in the cycle after edge k+2.
REQ-021 Requests SHALL be ignored while their ack is high; a requester still high after the ack cycle starts a new access.
REQ-022 Simultaneous dma_req and cpu_req SHALL serve DMA first and CPU immediately after; an access already in ACC/DONE SHALL never be aborted by a new request or by a download start.
REQ-023 A single-entry pending-write buffer SHALL capture any ioctl_wr (address and data) arriving in any state; LOAD SHALL drain it via LWR, which drives ram_we=1 for one cycle. The ioctl_wr spacing is at least 4 clk, so the buffer never overruns.
REQ-024 A buffered byte with ioctl_addr >= 2^AW SHALL NOT be written and SHALL set overflow; writes use ioctl_addr[AW-1:0].
REQ-025 In LOAD/LWR, dma_req SHALL be acked with the same 3-cycle latency but with dma_rdata=8'h00 and no RAM access; cpu_req SHALL NOT be acked.
REQ-026 cpu_hold SHALL be 1 from entry to LOAD until RELEASE exits.
REQ-027 When ioctl_download falls and the buffer is empty, LOAD SHALL go to RELEASE, which lasts 16 cycles via a 4-bit counter.
REQ-028 On RELEASE exit the block SHALL pulse load_done, go to IDLE and drop cpu_hold.
REQ-029 overflow SHALL clear only on reset or on the next entry to LOAD.
REQ-030 A download with a non-matching ioctl_index SHALL be ignored entirely: no hold, no writes.

Reset
REQ-031 While reset is high, the FSM SHALL be in IDLE; ram_we, cpu_ack, dma_ack, cpu_hold, load_done and overflow SHALL be 0; ram_addr, ram_wdata, cpu_rdata and dma_rdata SHALL be 0; the pending buffer and RELEASE counter SHALL be cleared.
REQ-032 Reset asserted mid-access or mid-download SHALL discard the access or byte with no ack and no write. If the download is still active after reset release, LOAD SHALL be re-entered on the first clk edge.

Verification
REQ-033 CPU write then read: cpu_req with cpu_we=1, cpu_addr=12'h0A5, cpu_wdata=8'h3C, then a read of 0x0A5 -> one ram_we pulse; cpu_ack at k+3 each time; read returns cpu_rdata=8'h3C.
REQ-034 Simultaneous requests: dma_req at addr 0x100 (RAM 0x11) and cpu_req at addr 0x200 (RAM 0x22) in the same cycle -> dma_ack with 8'h11 first, cpu_ack with 8'h22 exactly 3 cycles later.
REQ-035 Download: index 1, bytes 8'h7A, 8'hF8, 8'h00 at addresses 0..2 -> cpu_hold=1 throughout; RAM[0..2] holds those bytes; load_done pulses 16 cycles after the download falls; cpu_hold then drops.
REQ-036 Overflow and DMA during load: a byte at ioctl_addr=25'h1000 with AW=12 -> no ram_we, overflow=1; dma_req during LOAD -> dma_ack with 8'h00; overflow clears at the next download start.
REQ-037 Download collision: download starts while a CPU read is in ACC -> the CPU read completes with correct data, then LOAD. An ioctl_wr arriving during DONE -> the buffered byte is written in LWR.
REQ-038 Async reset: reset asserted in LOAD after 1 of 3 bytes -> all outputs 0 immediately. Download still high after release -> LOAD re-entered; remaining bytes are written.

Source files
------------

// File: rtl/ram_arbiter.sv
// Arbitrates one synchronous byte RAM between CPU and video DMA, and takes the
// RAM over to load an ioctl image download, holding the CPU until it is done.
module ram_arbiter #(
  parameter int unsigned AW         = 12,
  parameter logic [7:0]  LOAD_INDEX = 8'd1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [7:0]    cpu_rdata,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  output logic          dma_ack,
  output logic [7:0]    dma_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          overflow
);

  localparam int unsigned IOW = 25;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ACC     = 3'd1;
  localparam logic [2:0] S_DONE    = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_LWR     = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;

  logic [2:0]     state_q, state_d;
  logic           sel_dma_q, sel_dma_d;
  logic [AW-1:0]  ram_addr_q, ram_addr_d;
  logic           ram_we_q, ram_we_d;
  logic [7:0]     ram_wdata_q, ram_wdata_d;
  logic           cpu_ack_q, cpu_ack_d;
  logic [7:0]     cpu_rdata_q, cpu_rdata_d;
  logic           dma_ack_q, dma_ack_d;
  logic [7:0]     dma_rdata_q, dma_rdata_d;
  logic           cpu_hold_q, cpu_hold_d;
  logic           load_done_q, load_done_d;
  logic           overflow_q, overflow_d;
  logic           pend_vld_q, pend_vld_d;
  logic [IOW-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]     pend_data_q, pend_data_d;
  logic [3:0]     rel_cnt_q, rel_cnt_d;
  logic [1:0]     dpipe_q, dpipe_d;

  logic dl_match_c, cpu_go_c, dma_go_c, pend_ovf_c, in_load_c;

  always_comb begin
    dl_match_c = ioctl_download && (ioctl_index == LOAD_INDEX);
    cpu_go_c   = cpu_req && !cpu_ack_q;
    dma_go_c   = dma_req && !dma_ack_q;
    pend_ovf_c = (pend_addr_q >> AW) != IOW'(0);
    in_load_c  = (state_q == S_LOAD) || (state_q == S_LWR);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    sel_dma_d   = sel_dma_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_ack_d   = 1'b0;
    dma_rdata_d = dma_rdata_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = 1'b0;
    overflow_d  = overflow_q;
    pend_vld_d  = pend_vld_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    rel_cnt_d   = rel_cnt_q;
    dpipe_d     = {dpipe_q[0], 1'b0};

    // DMA served during a load: same latency, no RAM access, zero data
    if (dpipe_q[1]) begin
      dma_ack_d   = 1'b1;
      dma_rdata_d = 8'h00;
    end
    if (in_load_c && dma_go_c && (dpipe_q == 2'b00)) begin
      dpipe_d[0] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (dl_match_c) begin
          state_d    = S_LOAD;
          cpu_hold_d = 1'b1;
          overflow_d = 1'b0;
        end else if (dma_go_c) begin
          state_d    = S_ACC;
          sel_dma_d  = 1'b1;
          ram_addr_d = dma_addr;
        end else if (cpu_go_c) begin
          state_d     = S_ACC;
          sel_dma_d   = 1'b0;
          ram_addr_d  = cpu_addr;
          ram_we_d    = cpu_we;
          ram_wdata_d = cpu_wdata;
        end
      end
      S_ACC: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (sel_dma_q) begin
          dma_ack_d   = 1'b1;
          dma_rdata_d = ram_rdata;
        end else begin
          cpu_ack_d   = 1'b1;
          cpu_rdata_d = ram_rdata;
        end
      end
      S_LOAD: begin
        if (pend_vld_q) begin
          state_d     = S_LWR;
          pend_vld_d  = 1'b0;
          ram_addr_d  = pend_addr_q[AW-1:0];
          ram_wdata_d = pend_data_q;
          if (pend_ovf_c) overflow_d = 1'b1;
          else            ram_we_d   = 1'b1;
        end else if (!ioctl_download) begin
          state_d   = S_RELEASE;
          rel_cnt_d = 4'd0;
        end
      end
      S_LWR: begin
        state_d = S_LOAD;
      end
      S_RELEASE: begin
        if (rel_cnt_q == 4'd15) begin
          state_d     = S_IDLE;
          load_done_d = 1'b1;
          cpu_hold_d  = 1'b0;
        end else begin
          rel_cnt_d = rel_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Capture after the drain so a new byte is never lost to a same-cycle clear
    if (ioctl_wr && dl_match_c) begin
      pend_vld_d  = 1'b1;
      pend_addr_d = ioctl_addr;
      pend_data_d = ioctl_dout;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sel_dma_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= 8'h00;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'h00;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= 8'h00;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= 8'h00;
      rel_cnt_q   <= 4'd0;
      dpipe_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      sel_dma_q   <= sel_dma_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_ack_q   <= dma_ack_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      overflow_q  <= overflow_d;
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      rel_cnt_q   <= rel_cnt_d;
      dpipe_q     <= dpipe_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: stimulus pushes expected acks, RAM writes and
// load_done pulses; a negedge monitor pops and compares them as the DUT presents them.
module tb_ram_arbiter;

  localparam int unsigned AW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = 25'd0;
  logic [7:0]    ioctl_dout = 8'd0;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_wdata = 8'd0;
  logic          cpu_ack;
  logic [7:0]    cpu_rdata;
  logic          dma_req = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic          dma_ack;
  logic [7:0]    dma_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata = 8'd0;
  logic          cpu_hold;
  logic          load_done;
  logic          overflow;

  ram_arbiter #(.AW(AW), .LOAD_INDEX(8'd1)) dut (
    .clk(clk), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: read data one clock after the address
  logic [7:0] mem [0:4095];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; bit chkd; int cyc; } exp_t;
  typedef struct { logic [11:0] addr; logic [7:0] data; } wr_t;

  exp_t q_cpu[$];
  exp_t q_dma[$];
  wr_t  q_wr[$];
  int   q_ld[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event
  always @(negedge clk) begin : monitor
    exp_t e;
    wr_t  w;
    int   c;
    if (cpu_ack) begin
      if (q_cpu.size() == 0) chk("cpu_ack_unexpected", 32'd1, 32'd0);
      else begin
        e = q_cpu.pop_front();
        chk("cpu_ack_cycle", cyc, e.cyc);
        if (e.chkd) chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
      end
    end
    if (dma_ack) begin
      if (q_dma.size() == 0) chk("dma_ack_unexpected", 32'd1, 32'd0);
      else begin
        e = q_dma.pop_front();
        chk("dma_ack_cycle", cyc, e.cyc);
        chk("dma_rdata", 32'(dma_rdata), 32'(e.data));
      end
    end
    if (ram_we) begin
      if (q_wr.size() == 0) chk("ram_we_unexpected", 32'(ram_addr), 32'hFFFF);
      else begin
        w = q_wr.pop_front();
        chk("ram_wr_addr", 32'(ram_addr), 32'(w.addr));
        chk("ram_wr_data", 32'(ram_wdata), 32'(w.data));
      end
    end
    if (load_done) begin
      if (q_ld.size() == 0) chk("load_done_unexpected", 32'd1, 32'd0);
      else begin
        c = q_ld.pop_front();
        chk("load_done_cycle", cyc, c);
      end
    end
  end

  task automatic wait_cpu_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = cpu_ack;
    end
    if (!seen) chk("cpu_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_dma_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = dma_ack;
    end
    if (!seen) chk("dma_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_load_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = load_done;
    end
    if (!seen) chk("load_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic cpu_access(input logic we, input logic [11:0] a, input logic [7:0] wd,
                            input logic [7:0] rd, input bit chkd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    q_cpu.push_back('{rd, chkd, cyc + 3});
    if (we) q_wr.push_back('{a, wd});
    wait_cpu_ack();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic dma_access(input logic [11:0] a, input logic [7:0] rd);
    @(negedge clk);
    dma_req = 1'b1; dma_addr = a;
    q_dma.push_back('{rd, 1'b1, cyc + 3});
    wait_dma_ack();
    dma_req = 1'b0;
  endtask

  task automatic ioctl_byte(input logic [24:0] a, input logic [7:0] d, input bit exp_wr);
    logic [24:0] av;
    av = a;
    @(negedge clk);
    ioctl_wr = 1'b1; ioctl_addr = av; ioctl_dout = d;
    if (exp_wr) q_wr.push_back('{av[11:0], d});
    @(negedge clk);
    ioctl_wr = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic end_download();
    @(negedge clk);
    ioctl_download = 1'b0;
    q_ld.push_back(cyc + 17);
    @(negedge clk);
    chk("hold_in_release", 32'(cpu_hold), 32'd1);
    wait_load_done();
    chk("hold_after_done", 32'(cpu_hold), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ram_we"},    32'(ram_we),    32'd0);
    chk({tag, "_ram_addr"},  32'(ram_addr),  32'd0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    chk({tag, "_cpu_ack"},   32'(cpu_ack),   32'd0);
    chk({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
    chk({tag, "_dma_ack"},   32'(dma_ack),   32'd0);
    chk({tag, "_dma_rdata"}, 32'(dma_rdata), 32'd0);
    chk({tag, "_cpu_hold"},  32'(cpu_hold),  32'd0);
    chk({tag, "_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_overflow"},  32'(overflow),  32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // CPU write then read-back, plus preload for the arbitration case
    cpu_access(1'b1, 12'h0A5, 8'h3C, 8'h00, 1'b0);
    cpu_access(1'b0, 12'h0A5, 8'h00, 8'h3C, 1'b1);
    cpu_access(1'b1, 12'h100, 8'h11, 8'h00, 1'b0);
    cpu_access(1'b1, 12'h200, 8'h22, 8'h00, 1'b0);
    dma_access(12'h100, 8'h11);

    // Simultaneous requests: DMA first, CPU three cycles after
    @(negedge clk);
    dma_req = 1'b1; dma_addr = 12'h100;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h200;
    q_dma.push_back('{8'h11, 1'b1, cyc + 3});
    q_cpu.push_back('{8'h22, 1'b1, cyc + 6});
    fork
      begin wait_dma_ack(); dma_req = 1'b0; end
      begin wait_cpu_ack(); cpu_req = 1'b0; end
    join

    // Non-matching index: no hold, no write
    @(negedge clk);
    ioctl_download = 1'b1; ioctl_index = 8'd2;
    ioctl_byte(25'h5, 8'h99, 1'b0);
    chk("other_index_hold", 32'(cpu_hold), 32'd0);
    ioctl_download = 1'b0;

    // Image download with overflow byte and DMA during load
    @(negedge clk);
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    ioctl_byte(25'h0, 8'h7A, 1'b1);
    chk("load_hold", 32'(cpu_hold), 32'd1);
    ioctl_byte(25'h1, 8'hF8, 1'b1);
    ioctl_byte(25'h2, 8'h00, 1'b1);
    chk("overflow_before", 32'(overflow), 32'd0);
    ioctl_byte(25'h1000, 8'h55, 1'b0);
    chk("overflow_set", 32'(overflow), 32'd1);
    dma_access(12'h100, 8'h00);
    chk("load_hold_dma", 32'(cpu_hold), 32'd1);
    end_download();
    chk("mem0", 32'(mem[0]), 32'h7A);
    chk("mem1", 32'(mem[1]), 32'hF8);
    chk("mem2", 32'(mem[2]), 32'h00);
    chk("mem_wrap_untouched", 32'(mem[0]), 32'h7A);
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Download starts while a CPU read is in ACC; byte arrives during DONE
    fork
      cpu_access(1'b0, 12'h001, 8'h00, 8'hF8, 1'b1);
      begin
        @(negedge clk);
        @(negedge clk);
        ioctl_download = 1'b1; ioctl_index = 8'd1;
        @(negedge clk);
        ioctl_wr = 1'b1; ioctl_addr = 25'h0A0; ioctl_dout = 8'h5E;
        q_wr.push_back('{12'h0A0, 8'h5E});
        @(negedge clk);
        ioctl_wr = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    chk("collision_hold", 32'(cpu_hold), 32'd1);
    chk("overflow_cleared", 32'(overflow), 32'd0);
    cpu_req = 1'b1; cpu_addr = 12'h0A5;
    repeat (8) @(negedge clk);
    cpu_req = 1'b0;
    end_download();
    chk("mem_a0", 32'(mem[12'h0A0]), 32'h5E);

    // Async reset mid-download, download still high after release
    @(negedge clk);
    ioctl_download = 1'b1; ioctl_index = 8'd1;
    ioctl_byte(25'h10, 8'hAA, 1'b1);
    chk("pre_reset_hold", 32'(cpu_hold), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_zero("async");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reentry_hold", 32'(cpu_hold), 32'd1);
    ioctl_byte(25'h11, 8'hBB, 1'b1);
    ioctl_byte(25'h12, 8'hCC, 1'b1);
    end_download();
    chk("mem10", 32'(mem[12'h010]), 32'hAA);
    chk("mem11", 32'(mem[12'h011]), 32'hBB);
    chk("mem12", 32'(mem[12'h012]), 32'hCC);

    repeat (4) @(negedge clk);
    chk("q_cpu_empty", q_cpu.size(), 32'd0);
    chk("q_dma_empty", q_dma.size(), 32'd0);
    chk("q_wr_empty",  q_wr.size(),  32'd0);
    chk("q_ld_empty",  q_ld.size(),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
